// File: rtl/vid_timing_pkg.sv
// Shared video mode description, stock mode constants and helpers for the
// raster timing generator.
package vid_timing_pkg;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
    logic        hs_pol;
    logic        vs_pol;
  } vid_mode_t;

  localparam vid_mode_t MODE_640x480_60 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33,
    hs_pol: 1'b0, vs_pol: 1'b0};

  localparam vid_mode_t MODE_1280x720_60 = '{
    h_active: 16'd1280, h_fp: 16'd110, h_sync: 16'd40, h_bp: 16'd220,
    v_active: 16'd720,  v_fp: 16'd5,   v_sync: 16'd5,  v_bp: 16'd20,
    hs_pol: 1'b1, vs_pol: 1'b1};

  // Sub-pixel counters only need to reach SCALE-1 <= 7.
  localparam int SUB_W = 3;

  function automatic int vid_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vid_delay_line.sv
// Fixed-depth enabled shift register that re-times sync/DE/window flags to
// match the pixel loader's read latency.
module vid_delay_line #(
  parameter int           W       = 4,
  parameter int           DEPTH   = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sr [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
    end else if (i_en) begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/vid_timing_gen.sv
// Raster timing generator with an integer-upscaled image window; issues
// per-slot loader requests and latency-matched HS/VS/DE/window flags.
module vid_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int IMG_W    = 225,
  parameter int IMG_H    = 225,
  parameter int SCALE    = 2,
  parameter int DATA_LAT = 1,
  parameter int CW       = 12
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [CW-1:0] i_img_x,
  input  logic [CW-1:0] i_img_y,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_de,
  output logic          o_win,
  output logic          o_req,
  output logic [CW-1:0] o_src_x,
  output logic [CW-1:0] o_src_y,
  output logic          o_frame_start
);

  localparam int H_TOTAL = vid_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vid_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL >= 2**CW || V_TOTAL >= 2**CW || SCALE < 1 || SCALE > 8 ||
      DATA_LAT < 1 || DATA_LAT > 7) begin : g_bad_cfg
    $error("vid_timing_gen: unsupported CW/SCALE/DATA_LAT for this mode");
  end

  localparam logic [CW-1:0]    H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]    V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]    H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0]    V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0]    HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0]    HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0]    VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0]    VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW:0]      H_LIM  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0]      V_LIM  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0]      W_EXT  = (CW+1)'(IMG_W * SCALE);
  localparam logic [CW:0]      H_EXT  = (CW+1)'(IMG_H * SCALE);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);

  // Widened by one bit so origin + extent can never wrap around.
  function automatic logic in_win(input logic [CW-1:0] pos, input logic [CW-1:0] org,
                                  input logic [CW:0] ext, input logic [CW:0] lim);
    logic [CW:0] p;
    logic [CW:0] o;
    p = {1'b0, pos};
    o = {1'b0, org};
    return (p >= o) && (p < o + ext) && (p < lim);
  endfunction

  logic [CW-1:0]    r_cnt_h, r_cnt_v, r_wx, r_wy, r_src_x, r_src_y, r_o_src_x, r_o_src_y;
  logic [SUB_W-1:0] r_sub_x, r_sub_y;
  logic             r_req_cur, r_req, r_fs;
  logic [CW-1:0]    w_h_n, w_v_n, w_wx, w_wy, w_src_x_n, w_src_y_n;
  logic [SUB_W-1:0] w_sub_x_n, w_sub_y_n;
  logic             w_h_wrap, w_fs_n, w_xin_n, w_yin_n, w_req_n, w_yin_c;
  logic             w_hs_c, w_vs_c, w_de_c;

  // Everything below is evaluated for the slot the counters move to next,
  // so all outputs can be registered alongside the counters.
  assign w_h_wrap = (r_cnt_h == H_LAST);
  assign w_h_n    = w_h_wrap ? '0 : r_cnt_h + 1'b1;
  assign w_v_n    = !w_h_wrap ? r_cnt_v : ((r_cnt_v == V_LAST) ? '0 : r_cnt_v + 1'b1);
  assign w_fs_n   = (w_h_n == '0) && (w_v_n == '0);
  assign w_wx     = w_fs_n ? i_img_x : r_wx;
  assign w_wy     = w_fs_n ? i_img_y : r_wy;
  assign w_xin_n  = in_win(w_h_n, w_wx, W_EXT, H_LIM);
  assign w_yin_n  = in_win(w_v_n, w_wy, H_EXT, V_LIM);
  assign w_req_n  = w_xin_n && w_yin_n;
  assign w_yin_c  = in_win(r_cnt_v, r_wy, H_EXT, V_LIM);

  always_comb begin
    w_sub_x_n = r_sub_x;
    w_src_x_n = r_src_x;
    if (w_h_n == w_wx) begin
      w_sub_x_n = '0;
      w_src_x_n = '0;
    end else if (w_xin_n) begin
      if (r_sub_x == SUB_LAST) begin
        w_sub_x_n = '0;
        w_src_x_n = r_src_x + 1'b1;
      end else begin
        w_sub_x_n = r_sub_x + 1'b1;
      end
    end
    w_sub_y_n = r_sub_y;
    w_src_y_n = r_src_y;
    if (w_fs_n) begin
      w_sub_y_n = '0;
      w_src_y_n = '0;
    end else if (w_h_wrap && w_yin_c) begin
      if (r_sub_y == SUB_LAST) begin
        w_sub_y_n = '0;
        w_src_y_n = r_src_y + 1'b1;
      end else begin
        w_sub_y_n = r_sub_y + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_h   <= H_LAST;
      r_cnt_v   <= V_LAST;
      r_wx      <= '0;
      r_wy      <= '0;
      r_sub_x   <= '0;
      r_sub_y   <= '0;
      r_src_x   <= '0;
      r_src_y   <= '0;
      r_req_cur <= 1'b0;
      r_req     <= 1'b0;
      r_fs      <= 1'b0;
      r_o_src_x <= '0;
      r_o_src_y <= '0;
    end else if (i_en) begin
      r_cnt_h   <= w_h_n;
      r_cnt_v   <= w_v_n;
      r_wx      <= w_wx;
      r_wy      <= w_wy;
      r_sub_x   <= w_sub_x_n;
      r_sub_y   <= w_sub_y_n;
      r_src_x   <= w_src_x_n;
      r_src_y   <= w_src_y_n;
      r_req_cur <= w_req_n;
      r_req     <= w_req_n;
      r_fs      <= w_fs_n;
      r_o_src_x <= w_req_n ? w_src_x_n : '0;
      r_o_src_y <= w_req_n ? w_src_y_n : '0;
    end else begin
      r_req     <= 1'b0;
      r_fs      <= 1'b0;
      r_o_src_x <= '0;
      r_o_src_y <= '0;
    end
  end

  assign o_req         = r_req;
  assign o_frame_start = r_fs;
  assign o_src_x       = r_o_src_x;
  assign o_src_y       = r_o_src_y;

  // Flags of the currently presented slot; the delay line lines them up with loader data.
  assign w_hs_c = ((r_cnt_h >= HS_BEG) && (r_cnt_h < HS_END)) ? HS_POL : ~HS_POL;
  assign w_vs_c = ((r_cnt_v >= VS_BEG) && (r_cnt_v < VS_END)) ? VS_POL : ~VS_POL;
  assign w_de_c = (r_cnt_h < H_ACT) && (r_cnt_v < V_ACT);

  vid_delay_line #(
    .W       (4),
    .DEPTH   (DATA_LAT),
    .RST_VAL ({~HS_POL, ~VS_POL, 2'b00})
  ) u_dly (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .i_en  (i_en),
    .i_d   ({w_hs_c, w_vs_c, w_de_c, r_req_cur}),
    .o_q   ({o_hs, o_vs, o_de, o_win})
  );

endmodule
